// File: rtl/bus_fabric.sv
// bus_fabric: registered region decoder and read mux between core and on-chip memories.
// Optional BUS_FABRIC_FAULT_EN adds a sticky unmapped-access flag and address.
module bus_fabric #(
  parameter int AW = 20,
  parameter int DW = 8,
  parameter int NREG = 3,
  parameter logic [AW-1:0] BASE0 = 20'h00000,
  parameter logic [AW-1:0] BASE1 = 20'hA0000,
  parameter logic [AW-1:0] BASE2 = 20'hBC000,
  parameter logic [AW-1:0] BASE3 = 20'hFFFFF,
  parameter logic [AW-1:0] LIMIT0 = 20'h10000,
  parameter logic [AW-1:0] LIMIT1 = 20'hB92C0,
  parameter logic [AW-1:0] LIMIT2 = 20'hBD000,
  parameter logic [AW-1:0] LIMIT3 = 20'hFFFFF,
  parameter int LAT0 = 0,
  parameter int LAT1 = 1,
  parameter int LAT2 = 1,
  parameter int LAT3 = 0,
  parameter logic [DW-1:0] DEFAULT_Q = 8'hFF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_d,
  input  logic              cpu_we,
  input  logic              cpu_req,
  output logic [DW-1:0]     cpu_q,
  output logic              cpu_ce,
  output logic [AW-1:0]     mem_a,
  output logic [DW-1:0]     mem_d,
  output logic [NREG-1:0]   mem_w,
  input  logic [NREG*DW-1:0] mem_q
`ifdef BUS_FABRIC_FAULT_EN
  ,
  output logic              fault,
  output logic [AW-1:0]     fault_a
`endif
);

  localparam logic [4*AW-1:0] BASES =
    {BASE3, BASE2, BASE1, BASE0};
  localparam logic [4*AW-1:0] LIMITS =
    {LIMIT3, LIMIT2, LIMIT1, LIMIT0};
  localparam logic [11:0] LATS =
    {3'(LAT3), 3'(LAT2), 3'(LAT1), 3'(LAT0)};

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic          hit;
  logic [1:0]    idx;
  logic [AW-1:0] base_sel;
  logic [2:0]    lat_sel;
  logic [AW-1:0] offset;
  logic [2:0]    cnt;
  logic [AW-1:0] hold_a;
  logic [1:0]    hold_idx;
  logic [3:0]    w_vec;
  logic [4*DW-1:0] q_pad;
  logic          rd_now;
  logic          rd_wait;

  // Region decode; scan downward so the lowest index wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (cpu_a >= BASES[i*AW +: AW] &&
          cpu_a < LIMITS[i*AW +: AW]) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
  end

  // Per-region lookups, offset and padded read data
  always_comb begin
    base_sel = BASES[idx*AW +: AW];
    lat_sel  = LATS[idx*3 +: 3];
    offset   = cpu_a - base_sel;
    q_pad    = '0;
    q_pad[NREG*DW-1:0] = mem_q;
  end

  // Next state, bus outputs and stall control
  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b1;
    mem_a     = offset;
    mem_d     = cpu_d;
    w_vec     = '0;
    rd_now    = 1'b0;
    rd_wait   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req && cpu_we && hit) begin
          w_vec = 4'b0001 << idx;
        end
        if (cpu_req && !cpu_we && hit) begin
          if (lat_sel == 3'd0) begin
            rd_now = 1'b1;
          end else begin
            rd_wait   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cpu_ce = 1'b0;
        mem_a  = hold_a;
        if (cnt == 3'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    mem_w = w_vec[NREG-1:0];
  end

  // State register, wait counter and address/index latch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_a   <= '0;
      hold_idx <= '0;
    end else begin
      state <= state_nxt;
      if (rd_wait) begin
        cnt      <= lat_sel;
        hold_a   <= offset;
        hold_idx <= idx;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  // Read data register: immediate, delayed or default capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_q <= DEFAULT_Q;
    end else if (rd_now) begin
      cpu_q <= q_pad[idx*DW +: DW];
    end else if (state == WAIT && cnt == 3'd1) begin
      cpu_q <= q_pad[hold_idx*DW +: DW];
    end else if (state == IDLE && cpu_req &&
                 !cpu_we && !hit) begin
      cpu_q <= DEFAULT_Q;
    end
  end

`ifdef BUS_FABRIC_FAULT_EN
  // Sticky record of the first unmapped access
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault   <= 1'b0;
      fault_a <= '0;
    end else if (state == IDLE && cpu_req &&
                 !hit && !fault) begin
      fault   <= 1'b1;
      fault_a <= cpu_a;
    end
  end
`else
  // Unmapped accesses are dropped without any record.
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed checks of decode, stalls, writes and reset abort.
// Region 2 is built with a latency of 3 to exercise multi-cycle waits.
module tb_bus_fabric;

  logic        clock;
  logic        reset_n;
  logic [19:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_we;
  logic        cpu_req;
  logic [7:0]  cpu_q;
  logic        cpu_ce;
  logic [19:0] mem_a;
  logic [7:0]  mem_d;
  logic [2:0]  mem_w;
  logic [23:0] mem_q;
`ifdef BUS_FABRIC_FAULT_EN
  logic        fault;
  logic [19:0] fault_a;
`endif

  int checks;
  int errors;

  bus_fabric #(
    .LAT1(1),
    .LAT2(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cpu_a(cpu_a),
    .cpu_d(cpu_d),
    .cpu_we(cpu_we),
    .cpu_req(cpu_req),
    .cpu_q(cpu_q),
    .cpu_ce(cpu_ce),
    .mem_a(mem_a),
    .mem_d(mem_d),
    .mem_w(mem_w),
    .mem_q(mem_q)
`ifdef BUS_FABRIC_FAULT_EN
    ,
    .fault(fault),
    .fault_a(fault_a)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic req,
                     input logic we,
                     input logic [19:0] a,
                     input logic [7:0] d);
    @(posedge clock);
    #1;
    cpu_req = req;
    cpu_we  = we;
    cpu_a   = a;
    cpu_d   = d;
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    cpu_a   = '0;
    cpu_d   = '0;
    cpu_we  = 1'b0;
    cpu_req = 1'b0;
    mem_q   = {8'h7E, 8'hC3, 8'h5A};
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    cyc(0, 0, 20'h0, 8'h0);
    check("rst_ce", cpu_ce, 1);
    check("rst_q", cpu_q, 8'hFF);
    check("rst_w", mem_w, 3'b000);

    cyc(1, 1, 20'h01234, 8'h5A);
    check("wr0_w", mem_w, 3'b001);
    check("wr0_a", mem_a, 20'h01234);
    check("wr0_d", mem_d, 8'h5A);
    check("wr0_ce", cpu_ce, 1);

    cyc(1, 0, 20'h01234, 8'h00);
    check("rd0_w", mem_w, 3'b000);
    check("rd0_ce", cpu_ce, 1);
    cyc(0, 0, 20'h01234, 8'h00);
    check("rd0_q", cpu_q, 8'h5A);
    check("rd0_ce1", cpu_ce, 1);

    cyc(1, 0, 20'hB8000, 8'h00);
    check("rd1_a0", mem_a, 20'h18000);
    check("rd1_ce0", cpu_ce, 1);
    cyc(1, 1, 20'h00100, 8'h99);
    check("rd1_ce1", cpu_ce, 0);
    check("rd1_a1", mem_a, 20'h18000);
    check("rd1_w1", mem_w, 3'b000);
    cyc(0, 0, 20'h00000, 8'h00);
    check("rd1_ce2", cpu_ce, 1);
    check("rd1_q", cpu_q, 8'hC3);

    cyc(1, 0, 20'hBC020, 8'h00);
    check("rd2_a0", mem_a, 20'h00020);
    cyc(0, 0, 20'h00000, 8'h00);
    check("rd2_ce1", cpu_ce, 0);
    cyc(0, 0, 20'h00000, 8'h00);
    check("rd2_ce2", cpu_ce, 0);
    check("rd2_a2", mem_a, 20'h00020);
    cyc(0, 0, 20'h00000, 8'h00);
    check("rd2_ce3", cpu_ce, 0);
    check("rd2_q3", cpu_q, 8'hC3);
    cyc(1, 1, 20'h01000, 8'h11);
    check("rd2_ce4", cpu_ce, 1);
    check("rd2_q", cpu_q, 8'h7E);
    check("b2b_w", mem_w, 3'b001);

    cyc(1, 1, 20'hBC010, 8'h22);
    check("wr2_w", mem_w, 3'b100);
    check("wr2_a", mem_a, 20'h00010);
    cyc(1, 1, 20'hC0000, 8'h33);
    check("wrun_w", mem_w, 3'b000);
    check("wrun_ce", cpu_ce, 1);

    cyc(1, 0, 20'hF0000, 8'h00);
    check("rdun_ce", cpu_ce, 1);
    cyc(1, 0, 20'hF0001, 8'h00);
    check("rdun_q", cpu_q, 8'hFF);
`ifdef BUS_FABRIC_FAULT_EN
    check("flt", fault, 1);
    check("flt_a", fault_a, 20'hF0000);
`endif
    cyc(1, 0, 20'h01234, 8'h00);
`ifdef BUS_FABRIC_FAULT_EN
    check("flt_a2", fault_a, 20'hF0000);
`endif
    cyc(0, 0, 20'h00000, 8'h00);
    check("rd0b_q", cpu_q, 8'h5A);

    cyc(1, 0, 20'hBC020, 8'h00);
    cyc(0, 0, 20'h00000, 8'h00);
    cyc(0, 0, 20'h00000, 8'h00);
    check("ab_ce", cpu_ce, 0);
    reset_n = 1'b0;
    #1;
    check("ab_ce_r", cpu_ce, 1);
    check("ab_q_r", cpu_q, 8'hFF);
`ifdef BUS_FABRIC_FAULT_EN
    check("ab_flt", fault, 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    cyc(0, 0, 20'h00000, 8'h00);
    check("ab_w", mem_w, 3'b000);
    check("ab_ce", cpu_ce, 1);
    check("ab_q", cpu_q, 8'hFF);
    cyc(0, 0, 20'h00000, 8'h00);
    check("ab_w2", mem_w, 3'b000);
    check("ab_ce2", cpu_ce, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
